// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the alu_seq block.
//   op_e     - 4-bit opcode encodings (12..15 are illegal)
//   FLG_*    - bit positions inside the 5-bit flags word {err, n, v, c, z}
//   state_e  - handshake FSM states
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_CLR  = 4'd0,
    OP_MASK = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_OR   = 4'd4,
    OP_AND  = 4'd5,
    OP_XOR  = 4'd6,
    OP_HOLD = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  localparam int FLG_Z   = 0;
  localparam int FLG_C   = 1;
  localparam int FLG_V   = 2;
  localparam int FLG_N   = 3;
  localparam int FLG_ERR = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial product per cycle,
// LSB of the multiplier first, WIDTH steps in total.
//   clk, rst   - clock, asynchronous active-high reset
//   start_i    - latch a_i/b_i and begin; only honoured while not busy
//   a_i, b_i   - operands (sampled on the start edge only)
//   busy_o     - iteration in progress
//   last_o     - the step taken on the next edge is the final one
//   product_o  - accumulator value after the current step (valid as the
//                final product when busy_o && last_o)
//   cnt_o      - remaining-step counter
module alu_seq_mul
  #(parameter int WIDTH = 32)
  (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [WIDTH-1:0]         a_i,
    input  logic [WIDTH-1:0]         b_i,
    output logic                     busy_o,
    output logic                     last_o,
    output logic [WIDTH-1:0]         product_o,
    output logic [$clog2(WIDTH)-1:0] cnt_o
  );

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [SHW-1:0]   cnt_q;
  logic             busy_q;

  // The step result is exposed combinationally so the top can capture the
  // final product on the same edge that retires the last step.
  always_comb begin
    acc_d = acc_q + (b_q[0] ? a_q : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= SHW'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy_o    = busy_q;
  assign last_o    = (cnt_q == '0);
  assign product_o = acc_d;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result and flags.
// Optional iterative multiplier enabled by defining ALU_SEQ_MUL_EN; without
// it opcode 11 is illegal and ready is constantly 1.
//
// Handshake: an op is accepted on a rising edge where start=1 and ready=1.
// Single-cycle ops raise done for exactly one cycle after the accepting edge
// with result/flags updated; MUL drops ready for WIDTH cycles, then raises
// done together with ready. start while ready=0 is ignored.
//
//   clk, rst      - clock, asynchronous active-high reset
//   start, opcode - request and operation select
//   a_in, b_in    - operands
//   ready, done   - handshake status / one-cycle completion pulse
//   result, flags - registered result and {err, n, v, c, z}
//   dbg_state_o   - current FSM state
module alu_seq
  import alu_seq_pkg::*;
  #(parameter int WIDTH = 32)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output state_e           dbg_state_o
  );

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;
  logic             done_q, done_d;

  // ---------------- single-cycle datapath ----------------
  logic [SHW-1:0]        sh;
  logic [WIDTH:0]        add_w, sub_w, shl_w, shr_w;
  logic signed [WIDTH:0] sra_s;
  logic [SHW:0]          pop;
  logic [WIDTH-1:0]      alu_res;
  logic [4:0]            alu_flg;
  logic                  alu_c, alu_v, illegal;

  always_comb begin
    sh    = b_in[SHW-1:0];
    add_w = {1'b0, a_in} + {1'b0, b_in};
    sub_w = {1'b0, a_in} - {1'b0, b_in};
    // An extra bit beside the operand catches the last bit shifted out;
    // a shift of 0 leaves it at 0.
    shl_w = {1'b0, a_in} << sh;
    shr_w = {a_in, 1'b0} >> sh;
    sra_s = $signed({a_in, 1'b0}) >>> sh;

    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + (SHW+1)'(b_in[i]);
    end

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_CLR:  alu_res = '0;
      OP_MASK: begin
        // Full popcount needs an explicit all-ones case.
        if (pop == (SHW+1)'(WIDTH)) alu_res = '1;
        else                        alu_res = ~({WIDTH{1'b1}} << pop);
      end
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                  (add_w[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];  // borrow
        alu_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_OR:   alu_res = a_in | b_in;
      OP_AND:  alu_res = a_in & b_in;
      OP_XOR:  alu_res = a_in ^ b_in;
      OP_HOLD: alu_res = '0;  // never written back
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SRA: begin
        alu_res = sra_s[WIDTH:1];
        alu_c   = sra_s[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  alu_res = '0;  // handled by the multiplier path
`endif
      default: illegal = 1'b1;
    endcase

    alu_flg = '0;
    if (illegal) begin
      alu_res          = '0;
      alu_flg[FLG_ERR] = 1'b1;
    end else begin
      alu_flg[FLG_Z] = (alu_res == '0);
      alu_flg[FLG_N] = alu_res[WIDTH-1];
      alu_flg[FLG_C] = alu_c;
      alu_flg[FLG_V] = alu_v;
    end
  end

  // ---------------- multiplier ----------------
`ifdef ALU_SEQ_MUL_EN
  logic             mul_start, mul_busy, mul_last;
  logic [WIDTH-1:0] mul_prod;
  logic [SHW-1:0]   mul_cnt;
  logic [4:0]       mul_flg;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (a_in),
    .b_i       (b_in),
    .busy_o    (mul_busy),
    .last_o    (mul_last),
    .product_o (mul_prod),
    .cnt_o     (mul_cnt)
  );

  always_comb begin
    mul_flg        = '0;
    mul_flg[FLG_Z] = (mul_prod == '0);
    mul_flg[FLG_N] = mul_prod[WIDTH-1];
  end
`endif

  // ---------------- handshake FSM ----------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          if (opcode != OP_HOLD) begin
            result_d = alu_res;
            flags_d  = alu_flg;
          end
`ifdef ALU_SEQ_MUL_EN
          if (opcode == OP_MUL) begin
            done_d    = 1'b0;
            result_d  = result_q;
            flags_d   = flags_q;
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end
`endif
        end
      end
      ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_busy && mul_last) begin
          result_d = mul_prod;
          flags_d  = mul_flg;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  assign ready = (state_q == ST_IDLE);
`else
  assign ready = 1'b1;
`endif
  assign done        = done_q;
  assign result      = result_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int WIDTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [3:0]       opcode = 4'd0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             ready, done;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;
  state_e           dbg_state;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .a_in        (a_in),
    .b_in        (b_in),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .flags       (flags),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH+4:0] exp_q[$];
  string            name_q[$];
  logic [WIDTH+4:0] e;
  string            en;
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL spurious_done: got result %h flags %b expected no done", result, flags);
      end else begin
        e  = exp_q.pop_front();
        en = name_q.pop_front();
        check({en, "_result"}, 64'(result), 64'(e[WIDTH+4:5]));
        check({en, "_flags"},  64'(flags),  64'(e[4:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input string name, input logic [3:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] er, input logic [4:0] ef);
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    a_in   = a;
    b_in   = b;
    exp_q.push_back({er, ef});
    name_q.push_back(name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_flags"},  64'(flags),  64'(0));
    check({tag, "_ready"},  64'(ready),  64'(1));
    check({tag, "_done"},   64'(done),   64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // flags = {err, n, v, c, z}
    issue("add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b00011);
    issue("sub_ovf",   OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00100);
    issue("mask_6",    OP_MASK, 32'h0,         32'h0000_00F3, 32'h0000_003F, 5'b00000);
    issue("mask_full", OP_MASK, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b01000);
    issue("mask_zero", OP_MASK, 32'h1234_5678, 32'h0,         32'h0000_0000, 5'b00001);
    issue("sra",       OP_SRA,  32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 5'b01000);
    issue("shl",       OP_SHL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 5'b00010);
    issue("shr",       OP_SHR,  32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 5'b00010);
    issue("shl_zero",  OP_SHL,  32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 5'b00000);
    issue("or",        OP_OR,   32'hF0F0_0000, 32'h0FF0_00FF, 32'hFFF0_00FF, 5'b01000);
    issue("and",       OP_AND,  32'hF0F0_0000, 32'h0FF0_00FF, 32'h00F0_0000, 5'b00000);
    issue("xor",       OP_XOR,  32'hF0F0_0000, 32'h0FF0_00FF, 32'hFF00_00FF, 5'b01000);
    issue("add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01100);
    issue("sub_borrow",OP_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 5'b01010);
    issue("add_small", OP_ADD,  32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 5'b00000);
    issue("hold_1",    OP_HOLD, 32'hDEAD_BEEF, 32'h1,         32'h0000_000B, 5'b00000);
    issue("clr",       OP_CLR,  32'hDEAD_BEEF, 32'h1,         32'h0000_0000, 5'b00001);
    issue("illegal13", 4'd13,   32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 5'b10000);
    issue("hold_2",    OP_HOLD, 32'h1,         32'h1,         32'h0000_0000, 5'b10000);
    idle(1);
    check("ready_after_single", 64'(ready), 64'(1));

`ifdef ALU_SEQ_MUL_EN
    issue("mul", OP_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 5'b00000);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      // Operand/opcode churn and a stray start must not disturb the MUL.
      start  = (i == 10);
      opcode = OP_ADD;
      a_in   = 32'h0000_0001;
      b_in   = 32'h0000_0001;
      check("mul_ready_low", 64'(ready), 64'(0));
      check("mul_done_low",  64'(done),  64'(0));
    end
    @(negedge clk);
    start = 1'b0;
    check("mul_ready_back", 64'(ready), 64'(1));
    check("mul_done_edge",  64'(done),  64'(1));
    idle(2);

    // Reset in the middle of a MUL: abandoned, no done afterwards.
    issue("mul_abort", OP_MUL, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 5'b00000);
    idle(4);
    #2 rst = 1'b1;
    void'(exp_q.pop_back());
    void'(name_q.pop_back());
    #1 check_reset_state("reset_mid_mul");
    @(negedge clk);
    rst = 1'b0;
    idle(WIDTH + 8);
`else
    issue("mul_illegal", OP_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0000_0000, 5'b10000);
    issue("hold_3",      OP_HOLD, 32'h0,        32'h0,         32'h0000_0000, 5'b10000);
    idle(1);
    check("ready_after_mul_illegal", 64'(ready), 64'(1));
    issue("add_pre_rst", OP_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 5'b00000);
    idle(3);
    #2 rst = 1'b1;
    #1 check_reset_state("reset_async");
    @(negedge clk);
    rst = 1'b0;
    idle(4);
`endif

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drain", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the processor's single-cycle 3-bit-opcode ALU. It widens the datapath to WIDTH bits and extends the opcode to 4 bits, adding shifts, a corrected popcount-to-mask op and status flags. It also adds an optional iterative multiplier. The block sits between the accumulator/register-read stage and writeback, and uses a start/ready/done handshake so the control unit can stall on multi-cycle ops.

## Interface
- WIDTH, 32, datapath width; power of two, ≥8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- opcode  in  4  operation select (encodings below)
- a_in  in  WIDTH  operand A (accumulator)
- b_in  in  WIDTH  operand B
- ready  out  1  high in IDLE; low while a multi-cycle op runs
- done  out  1  one-cycle pulse: result/flags updated this cycle
- result  out  WIDTH  registered result
- flags  out  5  {err, n, v, c, z}, registered

## Operation
- Opcodes:
  - 0 CLR: result=0.
  - 1 MASK: result = low popcount(b_in) bits set; popcount=WIDTH gives all ones.
  - 2 ADD: a+b.
  - 3 SUB: a−b.
  - 4 OR.
  - 5 AND.
  - 6 XOR.
  - 7 HOLD: result and flags unchanged; done still pulses.
  - 8 SHL: a << b[SHW-1:0].
  - 9 SHR: logical right shift.
  - 10 SRA: arithmetic right shift.
  - 11 MUL: low WIDTH bits of a*b, unsigned.
  - 12–15 illegal.
- Illegal opcode: result=0, err=1, other flags 0.
- Flags are computed from the new result on every op except HOLD.
  - z = (result==0).
  - n = result[WIDTH-1].
  - c = carry-out for ADD; c = borrow (a<b unsigned) for SUB; c = last bit shifted out for shifts; otherwise 0.
  - v = signed overflow for ADD/SUB; otherwise 0.
  - err = 0 for legal ops.
- FSM states:
  - IDLE → IDLE on start with a single-cycle op.
  - IDLE → MUL on start with opcode 11.
  - MUL → IDLE when the iteration counter reaches 0.
- MUL: operands latched at accept. One shift-add step per cycle, LSB first, WIDTH steps. Counter loads WIDTH−1.
- start with ready=0 is ignored: no queueing, no error.
- Operand and opcode changes after accept do not affect an in-flight MUL.

## Timing
- Reset (async assert, any state): state=IDLE, ready=1, done=0, result=0, flags=0, counter=0. An in-flight MUL is abandoned and produces no done.
- Reset release takes effect on the next rising edge; the first accept is possible on that edge.
- Single-cycle op accepted at edge N: result/flags/done valid after edge N, so latency is 1. done is low after edge N+1 unless a new op is accepted. ready stays 1, so back-to-back accepts are allowed every cycle.
- MUL accepted at edge N:
  - ready=0 from after edge N.
  - result, flags and done=1 appear after edge N+WIDTH, with ready=1 in the same cycle.
  - A new start is accepted at edge N+WIDTH+1 at the earliest.
- During MUL, result and flags hold their previous values.
- Shift amounts use only b[SHW-1:0]. A shift of 0 gives result=a and c=0.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode 11 performs the iterative MUL above, and the MUL state and counter are present.
- ALU_SEQ_MUL_EN undefined: opcode 11 is treated as illegal (single cycle, result=0, err=1). The FSM reduces to IDLE only, and ready is tied to 1.

## Structure
- Package alu_seq_pkg holds:
  - the opcode enum (OP_CLR … OP_MUL);
  - the flag bit-index constants (FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3, FLG_ERR=4);
  - the FSM state enum.
- Sub-module alu_seq_mul contains the iterative shift-add multiplier: start, operand latch, counter, busy and product output. It is instantiated only under ALU_SEQ_MUL_EN. The top level keeps the combinational ops, flag logic and handshake.

## Test plan
- Reset mid-MUL (WIDTH=32): accept MUL 7×9, assert rst at cycle 5 → result=0, flags=0, ready=1 immediately, no done pulse afterwards.
- ADD 0xFFFFFFFF+1 → result=0 after 1 cycle, z=1, c=1, v=0. Then SUB 0x80000000−1 on the next cycle → 0x7FFFFFFF, v=1, c=0.
- MASK with b=0x0000_00F3 (popcount 6) → 0x3F. With b=0xFFFFFFFF → 0xFFFFFFFF. With b=0 → 0, z=1.
- SRA a=0x80000010, b=4 → 0xF8000001, n=1, c=0. SHL a=0x80000001, b=1 → 0x00000002, c=1.
- MUL 0x0001_0003×0x0000_0005 with ALU_SEQ_MUL_EN → ready low for 32 cycles, done after edge N+32 with result 0x0005_000F. A start presented mid-op is ignored.
- Opcode 13, and opcode 11 without ALU_SEQ_MUL_EN → result=0, err=1, done after 1 cycle. HOLD afterwards → result and flags unchanged, done pulses.
